// File: rtl/dma_write_framer_pkg.sv
// Shared definitions for the DMA write framer: FSM encoding and default widths.
`ifndef AXI_WIDTH_DATA_IN
`define AXI_WIDTH_DATA_IN 128
`endif

package dma_write_framer_pkg;

  localparam int DEFAULT_DATA_WIDTH = `AXI_WIDTH_DATA_IN;
  localparam int DEFAULT_LEN_WIDTH  = 24;
  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int DEFAULT_FIFO_AW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } framer_state_t;

endpackage

// File: rtl/dma_write_framer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is always presented on dout.
module sync_fifo_fwft
  import dma_write_framer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_AW    = DEFAULT_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  // Asynchronous read keeps the head visible without a read-latency bubble.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_reg;
  logic [FIFO_AW-1:0]    rd_ptr_reg;
  logic [FIFO_AW:0]      count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = count_reg[FIFO_AW];
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dma_write_framer.sv
// Buffers accelerator result beats, counts them against a per-layer total and frames
// the final beat with m_last, pulsing done once the DMA has accepted it.
module dma_write_framer
  import dma_write_framer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int FIFO_AW    = DEFAULT_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  beat_total,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [LEN_WIDTH-1:0]  out_count
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  if (FIFO_DEPTH != (1 << FIFO_AW)) begin : g_depth_check
    $error("FIFO_DEPTH must equal 2**FIFO_AW");
  end

  framer_state_t        state_reg;
  framer_state_t        state_next;
  logic [LEN_WIDTH-1:0] total_q;
  logic [LEN_WIDTH-1:0] in_cnt_reg;
  logic [LEN_WIDTH-1:0] out_count_reg;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 s_hs;
  logic                 m_hs;
  logic                 start_ok;
  logic                 in_done;

  sync_fifo_fwft #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (s_hs),
    .pop  (m_hs),
    .din  (s_data),
    .dout (m_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign m_valid   = !fifo_empty;
  assign m_last    = m_valid && (out_count_reg == total_q - LEN_ONE);
  assign out_count = out_count_reg;
  assign s_hs      = s_valid && s_ready;
  assign m_hs      = m_valid && m_ready;
  assign start_ok  = (state_reg == IDLE) && start;
  // True when the input side has seen (or is seeing this cycle) its final beat.
  assign in_done   = s_hs ? ((in_cnt_reg + LEN_ONE) == total_q) : (in_cnt_reg == total_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (beat_total != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (in_done) begin
          state_next = (m_hs && m_last) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (m_hs && m_last) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b1;
    done    = 1'b0;
    s_ready = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      RUN:     s_ready = !fifo_full && (in_cnt_reg != total_q);
      DRAIN:   s_ready = 1'b0;
      DONE:    done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q       <= '0;
      in_cnt_reg    <= '0;
      out_count_reg <= '0;
    end else if (start_ok) begin
      total_q       <= beat_total;
      in_cnt_reg    <= '0;
      out_count_reg <= '0;
    end else begin
      if (s_hs) begin
        in_cnt_reg <= in_cnt_reg + LEN_ONE;
      end
      if (m_hs) begin
        out_count_reg <= out_count_reg + LEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dma_write_framer.sv
// Directed bench for dma_write_framer: logs stream handshakes and checks framing, order,
// latency, done pulses and reset behaviour against hand-computed expectations.
module tb_dma_write_framer;

  localparam int DW = 128;
  localparam int LW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] beat_total;
  logic          busy;
  logic          done;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [LW-1:0] out_count;

  always #5 clk = ~clk;

  dma_write_framer #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .FIFO_DEPTH(16),
    .FIFO_AW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .beat_total(beat_total),
    .busy      (busy),
    .done      (done),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .out_count (out_count)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  bit send_fin;
  bit sready_seen;
  bit mvalid_seen;

  logic [DW-1:0] m_dq[$];
  bit            m_lq[$];
  int            m_cq[$];
  int            s_cq[$];
  int            done_cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so what is seen here is what the next edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        m_dq.push_back(m_data);
        m_lq.push_back(m_last);
        m_cq.push_back(cyc);
      end
      if (s_valid && s_ready) s_cq.push_back(cyc);
      if (done) done_cq.push_back(cyc);
      if (s_ready) sready_seen = 1'b1;
      if (m_valid) mvalid_seen = 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_log();
    m_dq.delete();
    m_lq.delete();
    m_cq.delete();
    s_cq.delete();
    done_cq.delete();
    sready_seen = 1'b0;
    mvalid_seen = 1'b0;
  endtask

  task automatic do_start(input logic [LW-1:0] n);
    start      = 1'b1;
    beat_total = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic send(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard   = 0;
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      at_neg();
      while (!s_ready && guard < 300) begin
        at_neg();
        guard++;
      end
      if (!s_ready) begin
        check_val("send_timeout", 128'd0, 128'd1);
        break;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int g;
    g = 0;
    while (done_cq.size() == 0 && g < budget) begin
      tick();
      g++;
    end
    check_val({tag, "_done_seen"}, 128'(done_cq.size() != 0), 128'd1);
  endtask

  task automatic wait_send(input string tag, input int budget);
    int g;
    g = 0;
    while (!send_fin && g < budget) begin
      tick();
      g++;
    end
    check_val({tag, "_send_fin"}, 128'(send_fin), 128'd1);
  endtask

  task automatic check_beats(input string tag, input logic [DW-1:0] base, input int n);
    check_val({tag, "_beats"}, 128'(m_dq.size()), 128'(n));
    for (int i = 0; i < n && i < m_dq.size(); i++) begin
      check_val($sformatf("%s_data%0d", tag, i), m_dq[i], base + DW'(i));
      check_val($sformatf("%s_last%0d", tag, i), 128'(m_lq[i]), 128'(i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    beat_total = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    m_ready    = 1'b0;
    send_fin   = 1'b0;
    repeat (3) tick();

    // Reset state
    at_neg();
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_m_valid", 128'(m_valid), 128'd0);
    check_val("rst_m_last", 128'(m_last), 128'd0);
    check_val("rst_s_ready", 128'(s_ready), 128'd0);
    check_val("rst_out_count", 128'(out_count), 128'd0);
    tick();
    rst = 1'b0;
    tick();

    // Four beats back-to-back, DMA always ready
    clear_log();
    m_ready = 1'b1;
    do_start(24'd4);
    send(4, 128'h1);
    wait_done("t1", 50);
    repeat (2) tick();
    check_beats("t1", 128'h1, 4);
    if (m_cq.size() == 4 && s_cq.size() == 4) begin
      check_val("t1_latency", 128'(m_cq[0] - s_cq[0]), 128'd1);
      check_val("t1_contig", 128'(m_cq[3] - m_cq[0]), 128'd3);
      if (done_cq.size() != 0) check_val("t1_done_cyc", 128'(done_cq[0] - m_cq[3]), 128'd1);
    end
    check_val("t1_done_cnt", 128'(done_cq.size()), 128'd1);
    at_neg();
    check_val("t1_out_count", 128'(out_count), 128'd4);
    tick();

    // Twenty beats with the DMA stalled during fill
    clear_log();
    m_ready = 1'b0;
    do_start(24'd20);
    send_fin = 1'b0;
    fork
      begin
        send(20, 128'h100);
        send_fin = 1'b1;
      end
    join_none
    repeat (30) tick();
    at_neg();
    check_val("t2_accepted", 128'(s_cq.size()), 128'd16);
    check_val("t2_s_ready", 128'(s_ready), 128'd0);
    check_val("t2_m_valid", 128'(m_valid), 128'd1);
    check_val("t2_m_data_hold", m_data, 128'h100);
    check_val("t2_busy", 128'(busy), 128'd1);
    check_val("t2_no_early_done", 128'(done_cq.size()), 128'd0);
    tick();
    m_ready = 1'b1;
    wait_send("t2", 200);
    wait_done("t2", 100);
    repeat (3) tick();
    check_beats("t2", 128'h100, 20);
    check_val("t2_done_cnt", 128'(done_cq.size()), 128'd1);
    at_neg();
    check_val("t2_out_count", 128'(out_count), 128'd20);
    tick();

    // Zero-length transfer
    clear_log();
    s_valid    = 1'b1;
    s_data     = 128'hdead;
    start      = 1'b1;
    beat_total = 24'd0;
    at_neg();
    check_val("t3_busy_pre", 128'(busy), 128'd0);
    tick();
    start = 1'b0;
    at_neg();
    check_val("t3_busy", 128'(busy), 128'd1);
    check_val("t3_done", 128'(done), 128'd1);
    tick();
    at_neg();
    check_val("t3_busy_after", 128'(busy), 128'd0);
    check_val("t3_done_after", 128'(done), 128'd0);
    repeat (3) tick();
    s_valid = 1'b0;
    check_val("t3_s_ready_seen", 128'(sready_seen), 128'd0);
    check_val("t3_m_valid_seen", 128'(mvalid_seen), 128'd0);
    check_val("t3_done_cnt", 128'(done_cq.size()), 128'd1);

    // Three-beat transfer with two surplus beats pending upstream
    clear_log();
    m_ready = 1'b1;
    do_start(24'd3);
    send(3, 128'h200);
    s_valid = 1'b1;
    s_data  = 128'h203;
    wait_done("t4", 50);
    repeat (4) tick();
    at_neg();
    check_val("t4_accepted", 128'(s_cq.size()), 128'd3);
    check_val("t4_s_ready", 128'(s_ready), 128'd0);
    check_val("t4_busy", 128'(busy), 128'd0);
    check_beats("t4a", 128'h200, 3);
    tick();
    clear_log();
    do_start(24'd2);
    send(2, 128'h203);
    wait_done("t4b", 50);
    repeat (2) tick();
    check_beats("t4b", 128'h203, 2);
    check_val("t4b_done_cnt", 128'(done_cq.size()), 128'd1);

    // Start pulse mid-transfer is ignored
    clear_log();
    m_ready = 1'b1;
    do_start(24'd6);
    send_fin = 1'b0;
    fork
      begin
        send(6, 128'h300);
        send_fin = 1'b1;
      end
    join_none
    begin
      int g;
      g = 0;
      while (s_cq.size() < 2 && g < 50) begin
        tick();
        g++;
      end
    end
    start      = 1'b1;
    beat_total = 24'd1;
    tick();
    start = 1'b0;
    at_neg();
    check_val("t5_busy", 128'(busy), 128'd1);
    tick();
    wait_send("t5", 100);
    wait_done("t5", 50);
    repeat (4) tick();
    check_beats("t5", 128'h300, 6);
    check_val("t5_done_cnt", 128'(done_cq.size()), 128'd1);
    at_neg();
    check_val("t5_out_count", 128'(out_count), 128'd6);
    tick();

    // Reset mid-transfer, then a fresh short transfer
    clear_log();
    m_ready = 1'b0;
    do_start(24'd10);
    send(5, 128'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    check_val("t6_busy", 128'(busy), 128'd0);
    check_val("t6_done", 128'(done), 128'd0);
    check_val("t6_m_valid", 128'(m_valid), 128'd0);
    check_val("t6_m_last", 128'(m_last), 128'd0);
    check_val("t6_s_ready", 128'(s_ready), 128'd0);
    check_val("t6_out_count", 128'(out_count), 128'd0);
    tick();
    m_ready = 1'b1;
    repeat (5) tick();
    check_val("t6_no_done", 128'(done_cq.size()), 128'd0);
    check_val("t6_no_beats", 128'(m_dq.size()), 128'd0);
    clear_log();
    do_start(24'd2);
    send(2, 128'h500);
    wait_done("t6b", 50);
    repeat (2) tick();
    check_beats("t6b", 128'h500, 2);
    check_val("t6b_done_cnt", 128'(done_cq.size()), 128'd1);
    at_neg();
    check_val("t6b_out_count", 128'(out_count), 128'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
